ddr_single_access: RTL and testbench
====================================

# ddr_single_access

Executes one 64-bit DDR3 read or write on the MIG native application interface in response to the single-access request produced by the ADC FIFO register block. Sits in the ui_clk domain, directly downstream of that block. Requests arrive as held levels, already synchronised into ui_clk, and are answered with a one-cycle done pulse that feeds the clk_usb return cdc_pulse. The block arbitrates for the shared app interface, issues the command, handles write-data and read-data handshakes, and returns read data.

## Interface
- pAPP_DW, 128: MIG app data width. One BL8 burst on the x16 device.
- pTIMEOUT_BITS, 16: width of the stall timeout counter.
- ui_clk  in  1  MIG user clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_write  in  1  level; start single write. Held until done is returned.
- req_read  in  1  level; start single read.
- req_addr  in  30  DDR address in 16-bit column units.
- req_wdata  in  64  write data.
- rdata  out  64  captured read data.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from request acceptance until REARM exit.
- timeout_err  out  1  sticky; set if a transaction timed out.
- init_calib_complete  in  1  MIG calibration done.
- arb_req  out  1  request for app interface ownership.
- arb_gnt  in  1  ownership granted.
- app_en, app_cmd[2:0], app_addr[29:0]  out  MIG command. Write is 3'b000; read is 3'b001.
- app_rdy  in  1.
- app_wdf_data[pAPP_DW-1:0], app_wdf_mask[pAPP_DW/8-1:0], app_wdf_wren, app_wdf_end  out.
- app_wdf_rdy  in  1.
- app_rd_data[pAPP_DW-1:0], app_rd_data_valid  in.

## Operation
- **States:** IDLE, WAIT_GNT, WRITE, RD_CMD, RD_DATA, DONE, REARM.
- **IDLE:** when init_calib_complete and (req_write or req_read), latch address, data and direction, assert arb_req, and go to WAIT_GNT. If both requests are high, write wins; only one done is produced.
- **WAIT_GNT:** on arb_gnt, go to WRITE or RD_CMD.
- **Address alignment:**
  - app_addr = {req_addr[29:3], 3'b000}, i.e. burst-aligned.
  - half = req_addr[2] selects the 64-bit lane: 0 selects [63:0]; 1 selects [127:64].
- **WRITE:**
  - Drive app_en and app_wdf_wren/app_wdf_end concurrently, with write data replicated into both lanes.
  - app_wdf_mask is active-high "do not write": 16'hFF00 for half=0, 16'h00FF for half=1.
  - Track command acceptance (app_en & app_rdy) and data acceptance (app_wdf_wren & app_wdf_rdy) with separate flags. Drop each strobe the cycle after its own acceptance.
  - Go to DONE when both flags are set; they may be set in either order or in the same cycle.
- **RD_CMD:** hold app_en until app_rdy, then go to RD_DATA.
- **RD_DATA:** on the first app_rd_data_valid, rdata <= selected lane and go to DONE. Any further valid beats in RD_DATA are ignored.
- **DONE:** done=1 for exactly one cycle; arb_req drops; go to REARM.
- **REARM:** wait until req_write=0 and req_read=0, then go to IDLE. This prevents a held level from retriggering.
- **rdata:** holds its value until the next read completes; it is unchanged by writes.
- **arb_gnt:** deasserting arb_gnt mid-transaction is not permitted by the arbiter contract; the block ignores it once past WAIT_GNT.

## Timing
- **Reset values:** all outputs 0, including rdata, timeout_err and app_wdf_mask; state is IDLE. Reset is asynchronous assert, synchronous deassert externally.
- **Registering:** all outputs are registered.
- **Write latency:** request, then arb_req on the next cycle. With arb_gnt, app_rdy and app_wdf_rdy all tied high, app_en/app_wdf_wren appear 2 cycles after the request and done follows 2 cycles after that.
- **Read latency:** done follows app_rd_data_valid by 1 cycle, and rdata is valid in the same cycle as done.
- **Reset mid-transaction:** all strobes drop immediately. The MIG command may be left incomplete; software re-issues.
- **busy:** falls on REARM exit.

## Configuration
- **DDR_SINGLE_TIMEOUT_EN defined:**
  - A pTIMEOUT_BITS counter clears on each state change and increments in WAIT_GNT, WRITE, RD_CMD and RD_DATA.
  - On all-ones it sets timeout_err, drops all app strobes, and goes to DONE, so done still pulses and rdata is unchanged.
  - timeout_err clears only on reset_n.
- **Not defined:** no counter; the block waits indefinitely; timeout_err is tied 0.

## Test plan
- Write to addr 0x40 with data 0x1122334455667788 and all ready signals high -> app_addr 0x40, mask 16'hFF00, data in both lanes, one done pulse 4 cycles after the request.
- Write to addr 0x44 with app_wdf_rdy delayed 5 cycles after app_rdy -> app_en is 1 cycle, app_wdf_wren is 6 cycles, mask 16'h00FF, a single done.
- Read addr 0x44 with app_rd_data = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0} valid 20 cycles after command -> rdata = 64'hAAAABBBBCCCCDDDD, done 1 cycle after valid.
- req_read held 50 cycles after done -> no second transaction; deasserting and reasserting it starts a new read.
- req_write=req_read=1, and separately init_calib_complete=0 -> a write only with one done; no arb_req until calibration.
- With DDR_SINGLE_TIMEOUT_EN, app_rdy held 0 -> after 65535 cycles timeout_err=1 and done pulses; reset_n low clears it.

Source files
------------

// File: rtl/ddr_single_access_if.sv
// MIG native application interface bundle shared by the single-access engine
// (master modport) and the memory controller side (slave modport).
interface ddr_single_access_if #(
  parameter int pAPP_DW = 128
) ();
  logic                 app_en;
  logic [2:0]           app_cmd;
  logic [29:0]          app_addr;
  logic                 app_rdy;
  logic [pAPP_DW-1:0]   app_wdf_data;
  logic [pAPP_DW/8-1:0] app_wdf_mask;
  logic                 app_wdf_wren;
  logic                 app_wdf_end;
  logic                 app_wdf_rdy;
  logic [pAPP_DW-1:0]   app_rd_data;
  logic                 app_rd_data_valid;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr_single_access.sv
// One 64-bit DDR3 read or write over the MIG app interface per held request level.
// Optional stall timeout enabled by defining DDR_SINGLE_TIMEOUT_EN.
module ddr_single_access #(
  parameter int pAPP_DW       = 128,
  parameter int pTIMEOUT_BITS = 16
) (
  input  logic        ui_clk,
  input  logic        reset_n,
  input  logic        req_write,
  input  logic        req_read,
  input  logic [29:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [63:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        timeout_err,
  input  logic        init_calib_complete,
  output logic        arb_req,
  input  logic        arb_gnt,
  ddr_single_access_if.master app
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_GNT = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] RD_CMD   = 3'd3;
  localparam logic [2:0] RD_DATA  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] REARM    = 3'd6;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam int         LANES  = pAPP_DW / 64;

  logic [2:0]  state, state_d;
  logic        tmo_hit, tmo_fire;
  logic        cmd_flag, data_flag;
  logic        lat_write;
  logic [27:0] lat_addr;
  logic [63:0] lat_wdata;
  logic        half;
  logic        unused_addr_lsb;

  assign half            = lat_addr[0];
  assign unused_addr_lsb = ^req_addr[1:0];

  // Active-high "do not write" mask leaving only the selected 64-bit lane enabled
  function automatic logic [pAPP_DW/8-1:0] lane_mask(input logic h);
    logic [pAPP_DW/8-1:0] m;
    int                   lo;
    m  = '1;
    lo = h ? 8 : 0;
    m[lo +: 8] = 8'h00;
    return m;
  endfunction

  function automatic logic [63:0] lane_sel(input logic [pAPP_DW-1:0] d, input logic h);
    int lo;
    lo = h ? 64 : 0;
    return d[lo +: 64];
  endfunction

`ifdef DDR_SINGLE_TIMEOUT_EN
  logic [pTIMEOUT_BITS-1:0] tmo_cnt;
  logic                     tmo_active;

  assign tmo_active = (state == WAIT_GNT) || (state == WRITE) ||
                      (state == RD_CMD)   || (state == RD_DATA);
  assign tmo_hit    = tmo_active && (&tmo_cnt);

  always_ff @(posedge ui_clk or negedge reset_n) begin
    if (!reset_n)
      tmo_cnt <= '0;
    else if (state_d != state)
      tmo_cnt <= '0;
    else if (tmo_active)
      tmo_cnt <= tmo_cnt + {{(pTIMEOUT_BITS-1){1'b0}}, 1'b1};
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Normal completion takes priority over a timeout landing in the same cycle
  always_comb begin
    state_d  = state;
    tmo_fire = 1'b0;
    case (state)
      IDLE:
        if (init_calib_complete && (req_write || req_read)) state_d = WAIT_GNT;
      WAIT_GNT:
        if (arb_gnt)      state_d = lat_write ? WRITE : RD_CMD;
        else if (tmo_hit) begin state_d = DONE; tmo_fire = 1'b1; end
      WRITE:
        if (cmd_flag && data_flag) state_d = DONE;
        else if (tmo_hit)          begin state_d = DONE; tmo_fire = 1'b1; end
      RD_CMD:
        if (app.app_en && app.app_rdy) state_d = RD_DATA;
        else if (tmo_hit)              begin state_d = DONE; tmo_fire = 1'b1; end
      RD_DATA:
        if (app.app_rd_data_valid) state_d = DONE;
        else if (tmo_hit)          begin state_d = DONE; tmo_fire = 1'b1; end
      DONE:
        state_d = REARM;
      REARM:
        if (!req_write && !req_read) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Request payload is plain data: captured on acceptance, no reset needed
  always_ff @(posedge ui_clk) begin
    if (state == IDLE && state_d == WAIT_GNT) begin
      lat_write <= req_write;
      lat_addr  <= req_addr[29:2];
      lat_wdata <= req_wdata;
    end
  end

  always_ff @(posedge ui_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rdata            <= '0;
      done             <= 1'b0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
      arb_req          <= 1'b0;
      cmd_flag         <= 1'b0;
      data_flag        <= 1'b0;
      app.app_en       <= 1'b0;
      app.app_cmd      <= 3'b000;
      app.app_addr     <= '0;
      app.app_wdf_data <= '0;
      app.app_wdf_mask <= '0;
      app.app_wdf_wren <= 1'b0;
      app.app_wdf_end  <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      case (state)
        IDLE:
          if (state_d == WAIT_GNT) begin
            arb_req <= 1'b1;
            busy    <= 1'b1;
          end
        WAIT_GNT:
          if (state_d == WRITE) begin
            app.app_en       <= 1'b1;
            app.app_cmd      <= CMD_WR;
            app.app_addr     <= {lat_addr[27:1], 3'b000};
            app.app_wdf_data <= {LANES{lat_wdata}};
            app.app_wdf_mask <= lane_mask(half);
            app.app_wdf_wren <= 1'b1;
            app.app_wdf_end  <= 1'b1;
            cmd_flag         <= 1'b0;
            data_flag        <= 1'b0;
          end else if (state_d == RD_CMD) begin
            app.app_en   <= 1'b1;
            app.app_cmd  <= CMD_RD;
            app.app_addr <= {lat_addr[27:1], 3'b000};
          end
        WRITE: begin
          // Command and data channels complete independently, in either order
          cmd_flag         <= cmd_flag  | (app.app_en & app.app_rdy);
          data_flag        <= data_flag | (app.app_wdf_wren & app.app_wdf_rdy);
          app.app_en       <= app.app_en & ~app.app_rdy;
          app.app_wdf_wren <= app.app_wdf_wren & ~app.app_wdf_rdy;
          app.app_wdf_end  <= app.app_wdf_end & ~app.app_wdf_rdy;
        end
        RD_CMD:
          if (app.app_en && app.app_rdy) app.app_en <= 1'b0;
        RD_DATA:
          if (app.app_rd_data_valid) rdata <= lane_sel(app.app_rd_data, half);
        REARM:
          if (state_d == IDLE) busy <= 1'b0;
        default: ;
      endcase
      if (state_d == DONE && state != DONE) begin
        done             <= 1'b1;
        arb_req          <= 1'b0;
        app.app_en       <= 1'b0;
        app.app_wdf_wren <= 1'b0;
        app.app_wdf_end  <= 1'b0;
      end
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_single_access.sv
// Directed bench for ddr_single_access: table of single transactions plus
// hand-written calibration, reset and (optionally) timeout sequences.
`timescale 1ns/1ps
module tb_ddr_single_access;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_write, req_read;
  logic [29:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] rdata;
  logic        done, busy, timeout_err;
  logic        init_calib_complete;
  logic        arb_req, arb_gnt;

  int checks = 0;
  int errors = 0;

  ddr_single_access_if #(.pAPP_DW(128)) app_bus ();

  ddr_single_access #(.pAPP_DW(128), .pTIMEOUT_BITS(16)) dut (
    .ui_clk              (clk),
    .reset_n             (reset_n),
    .req_write           (req_write),
    .req_read            (req_read),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .rdata               (rdata),
    .done                (done),
    .busy                (busy),
    .timeout_err         (timeout_err),
    .init_calib_complete (init_calib_complete),
    .arb_req             (arb_req),
    .arb_gnt             (arb_gnt),
    .app                 (app_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [29:0] addr;
    logic [63:0] wdata;
    logic [127:0] rd_data;
    int          wdf_dly;
    int          vld_dly;
    int          hold;
    logic [29:0] e_addr;
    logic [2:0]  e_cmd;
    logic [15:0] e_mask;
    int          e_done_t;
    int          e_wren;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int t, en_first, cmd_cyc, done_t, done_cnt, en_cnt, wren_cnt, wend_cnt, arb_t;
    logic [29:0]  c_addr;
    logic [2:0]   c_cmd;
    logic [15:0]  c_mask;
    logic [127:0] c_wdata;
    logic         busy_at_done;
    string        tag;
    tag = $sformatf("v%0d", idx);
    en_first = -1; cmd_cyc = -1; done_t = -1; arb_t = -1;
    done_cnt = 0; en_cnt = 0; wren_cnt = 0; wend_cnt = 0;
    c_addr = '0; c_cmd = '0; c_mask = '0; c_wdata = '0; busy_at_done = 1'b0;
    @(negedge clk);
    req_write = v.wr; req_read = v.rd; req_addr = v.addr; req_wdata = v.wdata;
    app_bus.app_rd_data       = v.rd_data;
    app_bus.app_rdy           = 1'b1;
    app_bus.app_wdf_rdy       = (v.wdf_dly == 0);
    app_bus.app_rd_data_valid = 1'b0;
    for (t = 1; t <= 200; t++) begin
      if (done_cnt > 0 && t > done_t + v.hold) break;
      @(negedge clk);
      if (arb_t < 0 && arb_req) arb_t = t;
      if (app_bus.app_en) begin
        en_cnt++;
        if (en_first < 0) begin
          en_first = t;
          c_addr = app_bus.app_addr; c_cmd = app_bus.app_cmd;
          c_mask = app_bus.app_wdf_mask; c_wdata = app_bus.app_wdf_data;
        end
      end
      if (app_bus.app_wdf_wren) wren_cnt++;
      if (app_bus.app_wdf_end)  wend_cnt++;
      if (done) begin
        done_cnt++;
        if (done_t < 0) begin done_t = t; busy_at_done = busy; end
      end
      app_bus.app_wdf_rdy       = (en_first < 0) ? (v.wdf_dly == 0) : (t >= en_first + v.wdf_dly);
      app_bus.app_rd_data_valid = (cmd_cyc >= 0) && (t == cmd_cyc + v.vld_dly);
      if (cmd_cyc < 0 && app_bus.app_en && app_bus.app_rdy && app_bus.app_cmd == 3'b001) cmd_cyc = t;
    end
    chk({tag, " arb_req_cycle"}, arb_t, 1);
    chk({tag, " done_cycle"}, done_t, v.e_done_t);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " app_addr"}, c_addr, v.e_addr);
    chk({tag, " app_cmd"}, c_cmd, v.e_cmd);
    chk({tag, " app_en_cycles"}, en_cnt, 1);
    chk({tag, " busy_at_done"}, busy_at_done, 1'b1);
    chk({tag, " rdata"}, rdata, v.e_rdata);
    if (v.wr) begin
      chk({tag, " wdf_mask"}, c_mask, v.e_mask);
      chk({tag, " wdf_data"}, c_wdata, {v.wdata, v.wdata});
      chk({tag, " wren_cycles"}, wren_cnt, v.e_wren);
      chk({tag, " wend_cycles"}, wend_cnt, v.e_wren);
    end
    req_write = 1'b0; req_read = 1'b0;
    app_bus.app_rd_data_valid = 1'b0;
    app_bus.app_wdf_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " busy_after_release"}, busy, 1'b0);
    chk({tag, " arb_req_after_release"}, arb_req, 1'b0);
  endtask

  initial begin
    int   bad;
    int   seen;
    vecs[0] = '{1'b1, 1'b0, 30'h40, 64'h1122334455667788, 128'h0, 0, 1000, 2,
                30'h40, 3'b000, 16'hFF00, 4, 1, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 30'h44, 64'hCAFEF00D12345678, 128'h0, 5, 1000, 2,
                30'h40, 3'b000, 16'h00FF, 9, 6, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 30'h44, 64'h0, {64'hAAAABBBBCCCCDDDD, 64'h0}, 0, 20, 50,
                30'h40, 3'b001, 16'h0, 23, 0, 64'hAAAABBBBCCCCDDDD};
    vecs[3] = '{1'b0, 1'b1, 30'h1239, 64'h0, {64'hDEADBEEFDEADBEEF, 64'h0123456789ABCDEF}, 0, 3, 2,
                30'h1238, 3'b001, 16'h0, 6, 0, 64'h0123456789ABCDEF};
    vecs[4] = '{1'b1, 1'b0, 30'h3FFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'h0, 0, 1000, 2,
                30'h3FFFFFF8, 3'b000, 16'h00FF, 4, 1, 64'h0123456789ABCDEF};
    vecs[5] = '{1'b1, 1'b1, 30'h8, 64'h0F0F0F0F0F0F0F0F, 128'h0, 0, 1000, 2,
                30'h8, 3'b000, 16'hFF00, 4, 1, 64'h0123456789ABCDEF};

    reset_n = 1'b0;
    req_write = 1'b0; req_read = 1'b0; req_addr = '0; req_wdata = '0;
    init_calib_complete = 1'b1; arb_gnt = 1'b1;
    app_bus.app_rdy = 1'b1; app_bus.app_wdf_rdy = 1'b1;
    app_bus.app_rd_data = '0; app_bus.app_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst rdata", rdata, 64'h0);
    chk("rst done", done, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst timeout_err", timeout_err, 1'b0);
    chk("rst arb_req", arb_req, 1'b0);
    chk("rst app_en", app_bus.app_en, 1'b0);
    chk("rst wdf_wren", app_bus.app_wdf_wren, 1'b0);
    chk("rst wdf_mask", app_bus.app_wdf_mask, 16'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // no request accepted until calibration completes
    init_calib_complete = 1'b0;
    req_write = 1'b1; req_addr = 30'h10; req_wdata = 64'h5555AAAA5555AAAA;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (arb_req || busy || done) bad++;
    end
    chk("calib_block", bad, 0);
    init_calib_complete = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("calib_done_after_enable", seen, 1);
    req_write = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a stalled write
    app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
    req_write = 1'b1; req_addr = 30'h20;
    repeat (4) @(negedge clk);
    chk("mid app_en_before_reset", app_bus.app_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid app_en", app_bus.app_en, 1'b0);
    chk("mid wdf_wren", app_bus.app_wdf_wren, 1'b0);
    chk("mid arb_req", arb_req, 1'b0);
    chk("mid busy", busy, 1'b0);
    chk("mid rdata", rdata, 64'h0);
    req_write = 1'b0;
    app_bus.app_rdy = 1'b1; app_bus.app_wdf_rdy = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef DDR_SINGLE_TIMEOUT_EN
    app_bus.app_rdy = 1'b0;
    req_read = 1'b1; req_addr = 30'h44;
    seen = 0;
    for (int t = 0; t < 70000 && seen == 0; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("tmo done", seen, 1);
    chk("tmo timeout_err", timeout_err, 1'b1);
    chk("tmo rdata_unchanged", rdata, 64'h0);
    req_read = 1'b0; app_bus.app_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo sticky", timeout_err, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("tmo cleared_by_reset", timeout_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
`else
    chk("timeout_err_tied_low", timeout_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
